// File: rtl/ps2_msg_pkg.sv
// Shared scan-code constants and FSM state type for the PS/2 message buffer.
package ps2_msg_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;

  localparam logic [7:0] ASCII_DEL = 8'h7F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } ps2_state_t;

endpackage

// File: rtl/ps2_scan_to_ascii.sv
// Combinational set-2 make-code lookup: lowercase letters and space; everything else is not a char.
module ps2_scan_to_ascii
  import ps2_msg_pkg::*;
(
  input  logic [7:0] scan_code,
  output logic       is_char,
  output logic [7:0] ascii
);

  always_comb begin
    is_char = 1'b1;
    ascii   = 8'h00;
    case (scan_code)
      8'h1C:    ascii = 8'h61;
      8'h32:    ascii = 8'h62;
      8'h21:    ascii = 8'h63;
      8'h23:    ascii = 8'h64;
      8'h24:    ascii = 8'h65;
      8'h2B:    ascii = 8'h66;
      8'h34:    ascii = 8'h67;
      8'h33:    ascii = 8'h68;
      8'h43:    ascii = 8'h69;
      8'h3B:    ascii = 8'h6A;
      8'h42:    ascii = 8'h6B;
      8'h4B:    ascii = 8'h6C;
      8'h3A:    ascii = 8'h6D;
      8'h31:    ascii = 8'h6E;
      8'h44:    ascii = 8'h6F;
      8'h4D:    ascii = 8'h70;
      8'h15:    ascii = 8'h71;
      8'h2D:    ascii = 8'h72;
      8'h1B:    ascii = 8'h73;
      8'h2C:    ascii = 8'h74;
      8'h3C:    ascii = 8'h75;
      8'h2A:    ascii = 8'h76;
      8'h1D:    ascii = 8'h77;
      8'h22:    ascii = 8'h78;
      8'h35:    ascii = 8'h79;
      8'h1A:    ascii = 8'h7A;
      SC_SPACE: ascii = 8'h20;
      default:  is_char = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_message_buffer.sv
// Assembles PS/2 scan codes into a committed ASCII message with valid/ready hand-off and LCD echo.
// Optional feature macro: PS2_SHIFT_EN (shift keys produce uppercase letters).
module ps2_message_buffer
  import ps2_msg_pkg::*;
#(
  parameter int                DEPTH    = 16,
  parameter int                CHAR_W   = 8,
  parameter logic [CHAR_W-1:0] PAD_CHAR = 8'h20
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       scan_valid,
  input  logic [7:0]                 scan_code,
  input  logic                       msg_ready,
  output logic                       msg_valid,
  output logic [DEPTH*CHAR_W-1:0]    msg_data,
  output logic [$clog2(DEPTH+1)-1:0] msg_len,
  output logic                       char_valid,
  output logic [CHAR_W-1:0]          char_data,
  output logic                       overflow,
  output logic                       commit_drop
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  ps2_state_t state_q, state_d;

  logic [CHAR_W-1:0]       work_buf [DEPTH];
  logic [DEPTH*CHAR_W-1:0] buf_flat;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_dec;

  logic                    dec_is_char;
  logic [7:0]              dec_ascii;
  logic [CHAR_W-1:0]       char_ascii;

  logic do_char, do_bksp, do_enter;
  logic shift_held;

  ps2_scan_to_ascii u_lookup (
    .scan_code (scan_code),
    .is_char   (dec_is_char),
    .ascii     (dec_ascii)
  );

`ifdef PS2_SHIFT_EN
  logic shift_set, shift_clr;
  logic is_lower;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_held <= 1'b0;
    end else if (shift_set) begin
      shift_held <= 1'b1;
    end else if (shift_clr) begin
      shift_held <= 1'b0;
    end
  end

  assign is_lower   = (dec_ascii >= 8'h61) && (dec_ascii <= 8'h7A);
  assign char_ascii = CHAR_W'((shift_held && is_lower) ? (dec_ascii - 8'h20) : dec_ascii);
`else
  assign shift_held = 1'b0;
  assign char_ascii = CHAR_W'(dec_ascii);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Prefix decoding: only bare make codes and extended Enter produce actions.
  always_comb begin
    state_d  = state_q;
    do_char  = 1'b0;
    do_bksp  = 1'b0;
    do_enter = 1'b0;
`ifdef PS2_SHIFT_EN
    shift_set = 1'b0;
    shift_clr = 1'b0;
`endif
    if (scan_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (scan_code == SC_BREAK) begin
            state_d = ST_BREAK;
          end else if (scan_code == SC_EXT) begin
            state_d = ST_EXT;
          end else if (dec_is_char) begin
            do_char = 1'b1;
          end else if (scan_code == SC_BKSP) begin
            do_bksp = 1'b1;
          end else if (scan_code == SC_ENTER) begin
            do_enter = 1'b1;
          end
`ifdef PS2_SHIFT_EN
          if (scan_code == SC_LSHIFT || scan_code == SC_RSHIFT) begin
            shift_set = 1'b1;
          end
`endif
        end
        ST_BREAK: begin
          state_d = ST_IDLE;
`ifdef PS2_SHIFT_EN
          if (scan_code == SC_LSHIFT || scan_code == SC_RSHIFT) begin
            shift_clr = 1'b1;
          end
`endif
        end
        ST_EXT: begin
          if (scan_code == SC_BREAK) begin
            state_d = ST_EXT_BREAK;
          end else begin
            state_d  = ST_IDLE;
            do_enter = (scan_code == SC_ENTER);
          end
        end
        ST_EXT_BREAK: state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    buf_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      buf_flat[(DEPTH-1-i)*CHAR_W +: CHAR_W] = work_buf[i];
    end
  end

  assign count_dec = count - CNT_W'(1);

  // A commit may reuse the same cycle in which the consumer takes the previous message.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        work_buf[i] <= PAD_CHAR;
      end
      count       <= '0;
      msg_valid   <= 1'b0;
      msg_len     <= '0;
      msg_data    <= {DEPTH{PAD_CHAR}};
      char_valid  <= 1'b0;
      char_data   <= '0;
      overflow    <= 1'b0;
      commit_drop <= 1'b0;
    end else begin
      char_valid  <= 1'b0;
      commit_drop <= 1'b0;

      if (msg_valid && msg_ready) begin
        msg_valid <= 1'b0;
      end

      if (do_char) begin
        if (count < DEPTH_C) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == count) begin
              work_buf[i] <= char_ascii;
            end
          end
          count      <= count + CNT_W'(1);
          char_valid <= 1'b1;
          char_data  <= char_ascii;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (do_bksp && (count != '0)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == count_dec) begin
            work_buf[i] <= PAD_CHAR;
          end
        end
        count      <= count_dec;
        char_valid <= 1'b1;
        char_data  <= CHAR_W'(ASCII_DEL);
      end

      if (do_enter && (count != '0)) begin
        if (!msg_valid || msg_ready) begin
          msg_data  <= buf_flat;
          msg_len   <= count;
          msg_valid <= 1'b1;
          for (int i = 0; i < DEPTH; i++) begin
            work_buf[i] <= PAD_CHAR;
          end
          count    <= '0;
          overflow <= 1'b0;
        end else begin
          commit_drop <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_message_buffer.sv
// Directed self-checking bench for ps2_message_buffer (default DEPTH=16, CHAR_W=8).
module tb_ps2_message_buffer;

  logic         clock;
  logic         reset;
  logic         scan_valid;
  logic [7:0]   scan_code;
  logic         msg_ready;
  logic         msg_valid;
  logic [127:0] msg_data;
  logic [4:0]   msg_len;
  logic         char_valid;
  logic [7:0]   char_data;
  logic         overflow;
  logic         commit_drop;

  int pass_cnt;
  int total_cnt;

  logic       last_echo;
  logic [7:0] last_char;
  logic       last_drop;

  ps2_message_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .scan_valid  (scan_valid),
    .scan_code   (scan_code),
    .msg_ready   (msg_ready),
    .msg_valid   (msg_valid),
    .msg_data    (msg_data),
    .msg_len     (msg_len),
    .char_valid  (char_valid),
    .char_data   (char_data),
    .overflow    (overflow),
    .commit_drop (commit_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One-cycle scan strobe; samples the echo/drop outputs one cycle after the strobe.
  task automatic send_byte(input logic [7:0] code);
    @(negedge clock);
    scan_valid = 1'b1;
    scan_code  = code;
    @(negedge clock);
    scan_valid = 1'b0;
    scan_code  = 8'h00;
    last_echo  = char_valid;
    last_char  = char_data;
    last_drop  = commit_drop;
  endtask

  task automatic consume();
    @(negedge clock);
    msg_ready = 1'b1;
    @(negedge clock);
    msg_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; scan_valid = 1'b0; scan_code = 8'h00; msg_ready = 1'b0;
    repeat (3) @(negedge clock);
    total_cnt++;
    if (msg_valid !== 1'b0) $display("FAIL reset_msg_valid: got %b expected 0", msg_valid);
    else pass_cnt++;
    total_cnt++;
    if (msg_len !== 5'd0) $display("FAIL reset_msg_len: got %0d expected 0", msg_len);
    else pass_cnt++;
    total_cnt++;
    if (msg_data !== {16{8'h20}}) $display("FAIL reset_msg_data: got %h expected %h", msg_data, {16{8'h20}});
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0 || commit_drop !== 1'b0 || char_valid !== 1'b0 || char_data !== 8'h00)
      $display("FAIL reset_flags: got ovf=%b drop=%b cv=%b cd=%h expected 0 0 0 00", overflow, commit_drop, char_valid, char_data);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic_commit();
    int echoes;
    logic [7:0] seq [7];
    seq = '{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32, 8'h5A};
    echoes = 0;
    for (int i = 0; i < 6; i++) begin
      send_byte(seq[i]);
      if (last_echo) echoes++;
      if (i == 3) begin
        total_cnt++;
        if (last_echo !== 1'b1 || last_char !== 8'h62) $display("FAIL basic_echo_b: got %b/%h expected 1/62", last_echo, last_char);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (echoes != 2) $display("FAIL basic_echo_count: got %0d expected 2", echoes);
    else pass_cnt++;
    send_byte(seq[6]);
    total_cnt++;
    if (msg_valid !== 1'b1 || msg_len !== 5'd2) $display("FAIL basic_commit: got valid=%b len=%0d expected 1/2", msg_valid, msg_len);
    else pass_cnt++;
    total_cnt++;
    if (msg_data !== {16'h6162, {14{8'h20}}}) $display("FAIL basic_data: got %h expected %h", msg_data, {16'h6162, {14{8'h20}}});
    else pass_cnt++;
    consume();
    total_cnt++;
    if (msg_valid !== 1'b0) $display("FAIL basic_handoff: got %b expected 0", msg_valid);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int echoes;
    echoes = 0;
    for (int i = 0; i < 16; i++) begin
      send_byte(8'h1C);
      if (last_echo && last_char == 8'h61) echoes++;
    end
    total_cnt++;
    if (echoes != 16) $display("FAIL ovf_echo_count: got %0d expected 16", echoes);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_early: got %b expected 0", overflow);
    else pass_cnt++;
    send_byte(8'h1C);
    total_cnt++;
    if (last_echo !== 1'b0) $display("FAIL ovf_17th_echo: got %b expected 0", last_echo);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow);
    else pass_cnt++;
    send_byte(8'h5A);
    total_cnt++;
    if (msg_valid !== 1'b1 || msg_len !== 5'd16 || msg_data !== {16{8'h61}})
      $display("FAIL ovf_commit: got valid=%b len=%0d data=%h expected 1/16/%h", msg_valid, msg_len, msg_data, {16{8'h61}});
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_cleared: got %b expected 0", overflow);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_backspace();
    send_byte(8'h66);
    total_cnt++;
    if (last_echo !== 1'b0) $display("FAIL bksp_empty_echo: got %b expected 0", last_echo);
    else pass_cnt++;
    send_byte(8'h1C);
    total_cnt++;
    if (last_echo !== 1'b1 || last_char !== 8'h61) $display("FAIL bksp_echo_a: got %b/%h expected 1/61", last_echo, last_char);
    else pass_cnt++;
    send_byte(8'h32);
    send_byte(8'h66);
    total_cnt++;
    if (last_echo !== 1'b1 || last_char !== 8'h7F) $display("FAIL bksp_echo_del: got %b/%h expected 1/7f", last_echo, last_char);
    else pass_cnt++;
    send_byte(8'h5A);
    total_cnt++;
    if (msg_valid !== 1'b1 || msg_len !== 5'd1 || msg_data !== {8'h61, {15{8'h20}}})
      $display("FAIL bksp_commit: got valid=%b len=%0d data=%h expected 1/1/%h", msg_valid, msg_len, msg_data, {8'h61, {15{8'h20}}});
    else pass_cnt++;
    consume();
    send_byte(8'h5A);
    total_cnt++;
    if (msg_valid !== 1'b0) $display("FAIL enter_empty: got %b expected 0", msg_valid);
    else pass_cnt++;
  endtask

  task automatic test_commit_drop();
    msg_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h5A);
    send_byte(8'h32);
    send_byte(8'h5A);
    total_cnt++;
    if (last_drop !== 1'b1) $display("FAIL drop_pulse: got %b expected 1", last_drop);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if (commit_drop !== 1'b0) $display("FAIL drop_one_cycle: got %b expected 0", commit_drop);
    else pass_cnt++;
    total_cnt++;
    if (msg_valid !== 1'b1 || msg_len !== 5'd1 || msg_data !== {8'h61, {15{8'h20}}})
      $display("FAIL drop_held: got valid=%b len=%0d data=%h expected 1/1/%h", msg_valid, msg_len, msg_data, {8'h61, {15{8'h20}}});
    else pass_cnt++;
    consume();
    total_cnt++;
    if (msg_valid !== 1'b0) $display("FAIL drop_handoff: got %b expected 0", msg_valid);
    else pass_cnt++;
    send_byte(8'h5A);
    total_cnt++;
    if (msg_valid !== 1'b1 || msg_data !== {8'h62, {15{8'h20}}})
      $display("FAIL drop_recommit: got valid=%b data=%h expected 1/%h", msg_valid, msg_data, {8'h62, {15{8'h20}}});
    else pass_cnt++;
    consume();
  endtask

  task automatic test_back_to_back();
    send_byte(8'h1C);
    send_byte(8'h5A);
    send_byte(8'h21);
    @(negedge clock);
    msg_ready  = 1'b1;
    scan_valid = 1'b1;
    scan_code  = 8'h5A;
    @(negedge clock);
    msg_ready  = 1'b0;
    scan_valid = 1'b0;
    total_cnt++;
    if (msg_valid !== 1'b1 || commit_drop !== 1'b0 || msg_data !== {8'h63, {15{8'h20}}})
      $display("FAIL b2b_commit: got valid=%b drop=%b data=%h expected 1/0/%h", msg_valid, commit_drop, msg_data, {8'h63, {15{8'h20}}});
    else pass_cnt++;
    consume();
  endtask

  task automatic test_extended();
    send_byte(8'h1C);
    send_byte(8'hE0);
    send_byte(8'h1C);
    total_cnt++;
    if (last_echo !== 1'b0) $display("FAIL ext_char_ignored: got %b expected 0", last_echo);
    else pass_cnt++;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h5A);
    total_cnt++;
    if (msg_valid !== 1'b0) $display("FAIL ext_break_enter: got %b expected 0", msg_valid);
    else pass_cnt++;
    send_byte(8'hE0);
    send_byte(8'h5A);
    total_cnt++;
    if (msg_valid !== 1'b1 || msg_len !== 5'd1) $display("FAIL ext_enter: got valid=%b len=%0d expected 1/1", msg_valid, msg_len);
    else pass_cnt++;
    consume();
  endtask

  task automatic test_shift();
    logic [15:0] expect_hi;
`ifdef PS2_SHIFT_EN
    expect_hi = 16'h4161;
`else
    expect_hi = 16'h6161;
`endif
    send_byte(8'h12);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h12);
    send_byte(8'h1C);
    send_byte(8'h5A);
    total_cnt++;
    if (msg_valid !== 1'b1 || msg_len !== 5'd2 || msg_data !== {expect_hi, {14{8'h20}}})
      $display("FAIL shift_commit: got valid=%b len=%0d data=%h expected 1/2/%h", msg_valid, msg_len, msg_data, {expect_hi, {14{8'h20}}});
    else pass_cnt++;
    consume();
  endtask

  task automatic test_mid_reset();
    send_byte(8'h1C);
    send_byte(8'h5A);
    send_byte(8'h32);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    total_cnt++;
    if (msg_valid !== 1'b0 || msg_data !== {16{8'h20}}) $display("FAIL midreset_async: got valid=%b data=%h expected 0/%h", msg_valid, msg_data, {16{8'h20}});
    else pass_cnt++;
    @(negedge clock);
    reset = 1'b0;
    send_byte(8'h5A);
    total_cnt++;
    if (msg_valid !== 1'b0) $display("FAIL midreset_buffer_cleared: got %b expected 0", msg_valid);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    last_echo = 1'b0;
    last_char = 8'h00;
    last_drop = 1'b0;
    test_reset();
    test_basic_commit();
    test_overflow();
    test_backspace();
    test_commit_drop();
    test_back_to_back();
    test_extended();
    test_shift();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
